// File: rtl/valu_strip_seq_pkg.sv
// Shared vector-ALU constants, opcode enumeration and sequencer state type.
// Imported by decode, the ALU block and the strip-mining sequencer.
package valu_strip_seq_pkg;

    localparam int LANES  = 8;
    localparam int MAX_VL = 64;
    localparam int REG_AW = 5;
    localparam int VL_W   = 7;
    localparam int GRP_W  = 3;
    localparam int BEAT_W = GRP_W + 1;
    localparam int LANE_W = $clog2(LANES);
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_MUL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic [VL_W-1:0] clamp_vl(input logic [VL_W-1:0] vl);
        return (vl > VL_W'(MAX_VL)) ? VL_W'(MAX_VL) : vl;
    endfunction

endpackage

// File: rtl/valu_lane_mask.sv
// Lane write mask for one element group: all lanes, except a partial last group.
// Purely combinational, no backpressure.
module valu_lane_mask
    import valu_strip_seq_pkg::*;
(
    input  logic [VL_W-1:0]   i_vl_c,
    input  logic [GRP_W-1:0]  i_grp,
    input  logic [BEAT_W-1:0] i_beats,
    output logic [LANES-1:0]  o_mask
);

    logic [LANE_W-1:0] w_rem;
    logic              w_last;

    assign w_rem  = LANE_W'(i_vl_c % VL_W'(LANES));
    assign w_last = ({1'b0, i_grp} == (i_beats - BEAT_W'(1)));

    always_comb begin
        o_mask = '1;
        if (w_last && (w_rem != '0)) begin
            o_mask = LANES'((32'd1 << w_rem) - 32'd1);
        end
    end

endmodule

// File: rtl/valu_strip_seq.sv
// Strip-mines one vector op into LANES-wide VRF read beats; write-back follows each read by 1 cycle.
// Last read at cycle B (beats + stalls), done at B+1, ready at B+2; stall only holds read issue.
module valu_strip_seq
    import valu_strip_seq_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [OP_W-1:0]   i_cmd_op,
    input  logic [REG_AW-1:0] i_cmd_vd,
    input  logic [REG_AW-1:0] i_cmd_vs1,
    input  logic [REG_AW-1:0] i_cmd_vs2,
    input  logic [VL_W-1:0]   i_cmd_vl,
    input  logic              i_stall,
    output logic              o_rd_en,
    output logic [REG_AW-1:0] o_rd_vs1,
    output logic [REG_AW-1:0] o_rd_vs2,
    output logic [GRP_W-1:0]  o_rd_grp,
    output logic [LANES-1:0]  o_valu_ena,
    output logic [OP_W-1:0]   o_valu_sel,
    output logic              o_wb_en,
    output logic [REG_AW-1:0] o_wb_vd,
    output logic [GRP_W-1:0]  o_wb_grp,
    output logic [LANES-1:0]  o_wb_mask,
    output logic              o_busy,
    output logic              o_done
);

    state_e            r_state;
    state_e            w_next;
    alu_op_e           r_op;
    logic [REG_AW-1:0] r_vd;
    logic [REG_AW-1:0] r_vs1;
    logic [REG_AW-1:0] r_vs2;
    logic [VL_W-1:0]   r_vl_c;
    logic [BEAT_W-1:0] r_beats;
    logic [GRP_W-1:0]  r_grp;
    logic              r_wb_en;
    logic [GRP_W-1:0]  r_wb_grp;
    logic [LANES-1:0]  r_wb_mask;

    logic [VL_W-1:0]   w_vl_c;
    logic [VL_W-1:0]   w_vl_rnd;
    logic [BEAT_W-1:0] w_beats;
    logic              w_accept;
    logic              w_issue;
    logic              w_last_grp;
    logic [LANES-1:0]  w_mask;

    // Rounding up cannot overflow VL_W: MAX_VL + LANES - 1 < 2**VL_W.
    assign w_vl_c     = clamp_vl(i_cmd_vl);
    assign w_vl_rnd   = w_vl_c + VL_W'(LANES - 1);
    assign w_beats    = BEAT_W'(w_vl_rnd >> LANE_W);
    assign w_accept   = (r_state == ST_IDLE) && i_cmd_valid;
    assign w_issue    = (r_state == ST_ISSUE) && !i_stall;
    assign w_last_grp = ({1'b0, r_grp} == (r_beats - BEAT_W'(1)));

    valu_lane_mask u_lane_mask (
        .i_vl_c  (r_vl_c),
        .i_grp   (r_grp),
        .i_beats (r_beats),
        .o_mask  (w_mask)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_cmd_ready = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_valu_sel  = '0;
        case (r_state)
            ST_IDLE: begin
                o_cmd_ready = !i_rst;
                if (i_cmd_valid) begin
                    w_next = (w_vl_c == '0) ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_busy     = 1'b1;
                o_valu_sel = r_op;
                if (w_issue && w_last_grp) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                o_busy     = 1'b1;
                o_valu_sel = r_op;
                o_done     = 1'b1;
                w_next     = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op    <= ALU_ADD;
            r_vd    <= '0;
            r_vs1   <= '0;
            r_vs2   <= '0;
            r_vl_c  <= '0;
            r_beats <= '0;
            r_grp   <= '0;
        end else if (w_accept) begin
            r_op    <= alu_op_e'(i_cmd_op);
            r_vd    <= i_cmd_vd;
            r_vs1   <= i_cmd_vs1;
            r_vs2   <= i_cmd_vs2;
            r_vl_c  <= w_vl_c;
            r_beats <= w_beats;
            r_grp   <= '0;
        end else if (w_issue) begin
            r_grp   <= r_grp + GRP_W'(1);
        end
    end

    // Write-back stage tracks the VRF's registered read data; stall never holds it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wb_en   <= 1'b0;
            r_wb_grp  <= '0;
            r_wb_mask <= '0;
        end else begin
            r_wb_en   <= w_issue;
            r_wb_grp  <= w_issue ? r_grp : '0;
            r_wb_mask <= w_issue ? w_mask : '0;
        end
    end

    assign o_rd_en    = w_issue;
    assign o_rd_vs1   = w_issue ? r_vs1 : '0;
    assign o_rd_vs2   = w_issue ? r_vs2 : '0;
    assign o_rd_grp   = w_issue ? r_grp : '0;
    assign o_wb_en    = r_wb_en;
    assign o_wb_vd    = r_wb_en ? r_vd : '0;
    assign o_wb_grp   = r_wb_grp;
    assign o_wb_mask  = r_wb_mask;
    assign o_valu_ena = r_wb_mask;

endmodule
